// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Upstream driver for an 8:1 multiplexer. A word accepted over a valid/ready
// handshake is held on the mux data bus while the select walks through all
// eight inputs, one index per enabled cycle. Together with the mux this forms
// an 8-bit parallel-to-serial converter. A one-cycle done pulse marks the end
// of each scan, and a new word can be taken in that same cycle.
// All outputs come straight from registers.

module mux_sel_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       adv,
    input  logic       abort,
    output logic [3:0] s,
    output logic [7:0] i,
    output logic       active,
    output logic       done
);

    // Scan direction: LSB-first counts up from 0, MSB-first counts down from 7.
    localparam logic [2:0] FIRST_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] data_q, data_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;

    logic       load;
    logic       atLast;
    logic [2:0] selStep;

    // Handshake acceptance, end-of-scan detection and the next select index.
    always_comb begin
        load    = 1'b0;
        atLast  = (sel_q == LAST_IDX);
        selStep = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
        if ((state_q == IDLE || state_q == DONE) && in_valid) begin
            load = 1'b1;
        end
    end

    // Next-state logic; the registered outputs are decoded from the next state
    // so that they line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        active_d = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b1;

        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d  = in_data;
                    sel_d   = FIRST_IDX;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Abort beats adv; the word stays on the bus, select returns to 0.
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                end else if (adv) begin
                    if (atLast) begin
                        state_d = DONE;
                    end else begin
                        sel_d = selStep;
                    end
                end
            end
            DONE: begin
                // A waiting word is taken here so scans run back to back.
                if (load) begin
                    data_d  = in_data;
                    sel_d   = FIRST_IDX;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
            end
        endcase

        active_d = (state_d == SCAN);
        done_d   = (state_d == DONE);
        ready_d  = (state_d != SCAN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            data_q   <= 8'd0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // The select's top bit is never used by an 8:1 mux and is tied low.
    assign s        = {1'b0, sel_q};
    assign i        = data_q;
    assign active   = active_q;
    assign done     = done_q;
    assign in_ready = ready_q;

endmodule
